// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: FSM encoding, op-select
// enum and the priority decoder that turns EX/MEM control bits into one op.
package mem_stage_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PUSH_HI = 2'd1;
    localparam logic [1:0] ST_POP_LO  = 2'd2;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_POP_PC,
        OP_PUSH_PC,
        OP_POP_CCR,
        OP_PUSH_CCR,
        OP_POP,
        OP_PUSH,
        OP_READ,
        OP_WRITE
    } op_sel_e;

    // Only one op is honoured per instruction; lower-priority bits are dropped.
    function automatic op_sel_e decode_op(
        input logic pop_pc,
        input logic push_pc,
        input logic pop_ccr,
        input logic push_ccr,
        input logic pop,
        input logic push,
        input logic rd,
        input logic wr
    );
        if (pop_pc)        return OP_POP_PC;
        else if (push_pc)  return OP_PUSH_PC;
        else if (pop_ccr)  return OP_POP_CCR;
        else if (push_ccr) return OP_PUSH_CCR;
        else if (pop)      return OP_POP;
        else if (push)     return OP_PUSH;
        else if (rd)       return OP_READ;
        else if (wr)       return OP_WRITE;
        else               return OP_NONE;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the memory-stage controller (master) and the data RAM
// (slave). Read data is combinational on addr; writes land on posedge when we=1.
interface mem_stage_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic              we;
    logic [15:0]       rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/mem_stage_ctrl_stack_pointer.sv
// Stack pointer register: modulo-2^ADDR_W increment/decrement with a sticky
// wrap flag. The wrapped value is kept so the stack keeps working after an error.
module mem_stage_ctrl_stack_pointer #(
    parameter int                ADDR_W  = 12,
    parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] sp_plus1,
    output logic              stack_err
);

    assign sp_plus1 = sp + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            sp        <= SP_INIT;
            stack_err <= 1'b0;
        end else if (dec) begin
            sp <= sp - ADDR_W'(1);
            if (sp == '0) stack_err <= 1'b1;
        end else if (inc) begin
            sp <= sp_plus1;
            if (sp == '1) stack_err <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: sequences LDD/STD, PUSH/POP, CCR push/pop and the
// two-cycle 32-bit PC push/pop, and builds the MEM/WB write-back data.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int                ADDR_W  = 12,
    parameter logic [ADDR_W-1:0] SP_INIT = ADDR_W'((1 << ADDR_W) - 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       ALU_result_mem,
    input  logic [15:0]       Rs_data_mem,
    input  logic [15:0]       Rd_data_mem,
    input  logic [2:0]        Rd_mem,
    input  logic              memRead_mem,
    input  logic              memWrite_mem,
    input  logic              regWrite_mem,
    input  logic              push_mem,
    input  logic              pop_mem,
    input  logic              pushPc_mem,
    input  logic              popPc_mem,
    input  logic              pushCCR_mem,
    input  logic              popCCR_mem,
    input  logic              int1_mem,
    input  logic              int2_mem,
    input  logic [31:0]       pc_in,
    input  logic [2:0]        ccr_in,
    mem_stage_ctrl_if.master  mem,
    output logic [15:0]       wb_data,
    output logic [2:0]        wb_Rd,
    output logic              wb_regWrite,
    output logic [31:0]       pc_pop,
    output logic              pc_pop_valid,
    output logic [2:0]        ccr_pop,
    output logic              ccr_pop_valid,
    output logic              stall,
    output logic [ADDR_W-1:0] sp,
    output logic              stack_err
);

    logic [1:0]        state, state_nxt;
    logic [15:0]       pc_hi;
    logic              pc_hi_en;
    logic [ADDR_W-1:0] sp_plus1;
    logic              sp_inc, sp_dec;
    logic [ADDR_W-1:0] addr_c;
    logic [15:0]       wdata_c;
    logic              we_c, stall_c, pcv_c, ccrv_c;
    op_sel_e           op;

    mem_stage_ctrl_stack_pointer #(
        .ADDR_W  (ADDR_W),
        .SP_INIT (SP_INIT)
    ) u_sp (
        .clk       (clk),
        .rst       (rst),
        .inc       (sp_inc),
        .dec       (sp_dec),
        .sp        (sp),
        .sp_plus1  (sp_plus1),
        .stack_err (stack_err)
    );

    assign op = decode_op(popPc_mem, pushPc_mem | int1_mem, popCCR_mem,
                          pushCCR_mem | int2_mem, pop_mem, push_mem,
                          memRead_mem, memWrite_mem);

    always_comb begin
        state_nxt = state;
        addr_c    = ALU_result_mem[ADDR_W-1:0];
        wdata_c   = 16'h0000;
        we_c      = 1'b0;
        stall_c   = 1'b0;
        pcv_c     = 1'b0;
        ccrv_c    = 1'b0;
        sp_inc    = 1'b0;
        sp_dec    = 1'b0;
        pc_hi_en  = 1'b0;
        wb_data   = ALU_result_mem;
        case (state)
            ST_PUSH_HI: begin
                addr_c    = sp;
                wdata_c   = pc_in[31:16];
                we_c      = 1'b1;
                sp_dec    = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_POP_LO: begin
                addr_c    = sp_plus1;
                pcv_c     = 1'b1;
                sp_inc    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                case (op)
                    OP_POP_PC: begin
                        addr_c    = sp_plus1;
                        pc_hi_en  = 1'b1;
                        stall_c   = 1'b1;
                        sp_inc    = 1'b1;
                        state_nxt = ST_POP_LO;
                    end
                    OP_PUSH_PC: begin
                        addr_c    = sp;
                        wdata_c   = pc_in[15:0];
                        we_c      = 1'b1;
                        stall_c   = 1'b1;
                        sp_dec    = 1'b1;
                        state_nxt = ST_PUSH_HI;
                    end
                    OP_POP_CCR: begin
                        addr_c = sp_plus1;
                        ccrv_c = 1'b1;
                        sp_inc = 1'b1;
                    end
                    OP_PUSH_CCR: begin
                        addr_c  = sp;
                        wdata_c = {13'b0, ccr_in};
                        we_c    = 1'b1;
                        sp_dec  = 1'b1;
                    end
                    OP_POP: begin
                        addr_c  = sp_plus1;
                        wb_data = mem.rdata;
                        sp_inc  = 1'b1;
                    end
                    OP_PUSH: begin
                        addr_c  = sp;
                        wdata_c = Rd_data_mem;
                        we_c    = 1'b1;
                        sp_dec  = 1'b1;
                    end
                    OP_READ:  wb_data = mem.rdata;
                    OP_WRITE: begin
                        wdata_c = Rs_data_mem;
                        we_c    = 1'b1;
                    end
                    default: ;
                endcase
            end
        endcase
    end

    // Reset overrides any in-flight transfer: no write, no pulse, no stall.
    assign mem.addr      = addr_c;
    assign mem.wdata     = wdata_c;
    assign mem.we        = we_c & ~rst;
    assign stall         = stall_c & ~rst;
    assign pc_pop_valid  = pcv_c & ~rst;
    assign ccr_pop_valid = ccrv_c & ~rst;
    assign pc_pop        = {pc_hi, mem.rdata};
    assign ccr_pop       = mem.rdata[2:0];
    assign wb_Rd         = Rd_mem;
    assign wb_regWrite   = regWrite_mem & ~stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pc_hi <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (pc_hi_en) pc_hi <= mem.rdata;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: stimulus queues expected values per cycle,
// a negedge monitor compares them and checks popped PC/CCR on their valid pulses.
module tb_mem_stage_ctrl;
    import mem_stage_pkg::*;

    localparam int ADDR_W = 12;
    localparam int S_SP = 0, S_STALL = 1, S_ERR = 2, S_WE = 3, S_ADDR = 4,
                   S_WDATA = 5, S_WB = 6, S_REGW = 7, S_PCV = 8, S_CCRV = 9, S_MEM = 10;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
        int          cyc;
        logic [11:0] aux;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [15:0] ALU_result_mem, Rs_data_mem, Rd_data_mem;
    logic [2:0]  Rd_mem, ccr_in;
    logic memRead_mem, memWrite_mem, regWrite_mem, push_mem, pop_mem;
    logic pushPc_mem, popPc_mem, pushCCR_mem, popCCR_mem, int1_mem, int2_mem;
    logic [31:0] pc_in;
    logic [15:0] wb_data;
    logic [2:0]  wb_Rd, ccr_pop;
    logic        wb_regWrite, pc_pop_valid, ccr_pop_valid, stall, stack_err;
    logic [31:0] pc_pop;
    logic [ADDR_W-1:0] sp;

    logic [15:0] ram [0:(1<<ADDR_W)-1];
    exp_t        sb[$];
    logic [31:0] pc_q[$];
    logic [2:0]  ccr_q[$];
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    mem_stage_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    mem_stage_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .ALU_result_mem(ALU_result_mem), .Rs_data_mem(Rs_data_mem), .Rd_data_mem(Rd_data_mem),
        .Rd_mem(Rd_mem), .memRead_mem(memRead_mem), .memWrite_mem(memWrite_mem),
        .regWrite_mem(regWrite_mem), .push_mem(push_mem), .pop_mem(pop_mem),
        .pushPc_mem(pushPc_mem), .popPc_mem(popPc_mem), .pushCCR_mem(pushCCR_mem),
        .popCCR_mem(popCCR_mem), .int1_mem(int1_mem), .int2_mem(int2_mem),
        .pc_in(pc_in), .ccr_in(ccr_in), .mem(bus.master),
        .wb_data(wb_data), .wb_Rd(wb_Rd), .wb_regWrite(wb_regWrite),
        .pc_pop(pc_pop), .pc_pop_valid(pc_pop_valid), .ccr_pop(ccr_pop),
        .ccr_pop_valid(ccr_pop_valid), .stall(stall), .sp(sp), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    assign bus.rdata = ram[bus.addr];
    always @(posedge clk) begin
        if (bus.we) ram[bus.addr] <= bus.wdata;
        cyc <= cyc + 1;
    end

    function automatic logic [31:0] actual(input int sel, input logic [11:0] aux);
        case (sel)
            S_SP:    return 32'(sp);
            S_STALL: return 32'(stall);
            S_ERR:   return 32'(stack_err);
            S_WE:    return 32'(bus.we);
            S_ADDR:  return 32'(bus.addr);
            S_WDATA: return 32'(bus.wdata);
            S_WB:    return 32'(wb_data);
            S_REGW:  return 32'(wb_regWrite);
            S_PCV:   return 32'(pc_pop_valid);
            S_CCRV:  return 32'(ccr_pop_valid);
            default: return 32'(ram[aux]);
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [31:0] a;
                a = actual(sb[i].sel, sb[i].aux);
                n_vec++;
                if (sb[i].cyc < cyc || a !== sb[i].val) begin
                    n_err++;
                    $display("FAIL %s: got %0h, want %0h", sb[i].name, a, sb[i].val);
                end
                sb.delete(i);
            end
        end
        if (pc_pop_valid) begin
            n_vec++;
            if (pc_q.size() == 0) begin
                n_err++;
                $display("FAIL pc_pop_unexpected: got %0h, want no pulse", pc_pop);
            end else begin
                logic [31:0] e;
                e = pc_q.pop_front();
                if (pc_pop !== e) begin
                    n_err++;
                    $display("FAIL pc_pop: got %0h, want %0h", pc_pop, e);
                end
            end
        end
        if (ccr_pop_valid) begin
            n_vec++;
            if (ccr_q.size() == 0) begin
                n_err++;
                $display("FAIL ccr_pop_unexpected: got %0h, want no pulse", ccr_pop);
            end else begin
                logic [2:0] e;
                e = ccr_q.pop_front();
                if (ccr_pop !== e) begin
                    n_err++;
                    $display("FAIL ccr_pop: got %0h, want %0h", ccr_pop, e);
                end
            end
        end
    end

    task automatic exp(input string nm, input int sel, input logic [31:0] v,
                       input logic [11:0] aux = 12'h000);
        exp_t e;
        e.name = nm; e.sel = sel; e.val = v; e.cyc = cyc; e.aux = aux;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        memRead_mem = 0; memWrite_mem = 0; regWrite_mem = 0; push_mem = 0; pop_mem = 0;
        pushPc_mem = 0; popPc_mem = 0; pushCCR_mem = 0; popCCR_mem = 0;
        int1_mem = 0; int2_mem = 0;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 16'h0000;
        rst = 1;
        clear_ctrl();
        ALU_result_mem = 0; Rs_data_mem = 0; Rd_data_mem = 0; Rd_mem = 3'd2;
        pc_in = 0; ccr_in = 0;
        step(); step();
        rst = 0;

        // 1: reset state
        exp("rst_sp", S_SP, 32'hFFF); exp("rst_stall", S_STALL, 0);
        exp("rst_err", S_ERR, 0);     exp("rst_we", S_WE, 0);
        step();

        // 2: push then pop
        push_mem = 1; Rd_data_mem = 16'hBEEF;
        exp("push_we", S_WE, 1); exp("push_addr", S_ADDR, 32'hFFF);
        exp("push_wdata", S_WDATA, 32'hBEEF);
        step();
        clear_ctrl(); pop_mem = 1;
        exp("push_sp", S_SP, 32'hFFE); exp("push_mem", S_MEM, 32'hBEEF, 12'hFFF);
        exp("pop_wb", S_WB, 32'hBEEF); exp("pop_we", S_WE, 0);
        step();
        clear_ctrl();
        exp("pop_sp", S_SP, 32'hFFF);

        // 3: PC push, then PC pop
        pushPc_mem = 1; regWrite_mem = 1; pc_in = 32'h1234_5678;
        exp("pushpc_stall", S_STALL, 1); exp("pushpc_regw", S_REGW, 0);
        exp("pushpc_lo", S_WDATA, 32'h5678); exp("pushpc_addr", S_ADDR, 32'hFFF);
        step();
        exp("pushhi_stall", S_STALL, 0); exp("pushhi_regw", S_REGW, 1);
        exp("pushhi_hi", S_WDATA, 32'h1234); exp("pushhi_addr", S_ADDR, 32'hFFE);
        exp("pushhi_we", S_WE, 1);
        step();
        clear_ctrl(); popPc_mem = 1;
        exp("pushpc_sp", S_SP, 32'hFFD); exp("pushpc_m0", S_MEM, 32'h5678, 12'hFFF);
        exp("pushpc_m1", S_MEM, 32'h1234, 12'hFFE);
        exp("poppc_stall", S_STALL, 1); exp("poppc_addr", S_ADDR, 32'hFFE);
        pc_q.push_back(32'h1234_5678);
        step();
        exp("poplo_stall", S_STALL, 0); exp("poplo_valid", S_PCV, 1);
        exp("poplo_addr", S_ADDR, 32'hFFF);
        step();
        clear_ctrl();
        exp("poppc_sp", S_SP, 32'hFFF); exp("poppc_valid_off", S_PCV, 0);

        // 4: CCR push/pop
        pushCCR_mem = 1; ccr_in = 3'b101;
        exp("pushccr_wdata", S_WDATA, 32'h0005); exp("pushccr_we", S_WE, 1);
        step();
        clear_ctrl(); popCCR_mem = 1;
        exp("pushccr_mem", S_MEM, 32'h0005, 12'hFFF); exp("popccr_valid", S_CCRV, 1);
        ccr_q.push_back(3'b101);
        step();
        clear_ctrl();
        exp("popccr_valid_off", S_CCRV, 0); exp("popccr_sp", S_SP, 32'hFFF);

        // 5: load/store and priority
        memWrite_mem = 1; ALU_result_mem = 16'h0010; Rs_data_mem = 16'h00A5;
        exp("st_we", S_WE, 1); exp("st_addr", S_ADDR, 32'h010);
        step();
        clear_ctrl(); memRead_mem = 1;
        exp("ld_wb", S_WB, 32'h00A5); exp("ld_we", S_WE, 0); exp("ld_sp", S_SP, 32'hFFF);
        step();
        push_mem = 1; Rd_data_mem = 16'h1111;
        exp("prio_addr", S_ADDR, 32'hFFF); exp("prio_wb", S_WB, 32'h0010);
        exp("prio_wdata", S_WDATA, 32'h1111);
        step();
        clear_ctrl(); pop_mem = 1;
        exp("prio_sp", S_SP, 32'hFFE); exp("st_mem", S_MEM, 32'h00A5, 12'h010);
        exp("prio_pop_wb", S_WB, 32'h1111);
        step();
        clear_ctrl();

        // 6: underflow wrap, then reset inside PUSH_HI
        pop_mem = 1;
        exp("wrap_addr", S_ADDR, 32'h000); exp("wrap_err_pre", S_ERR, 0);
        step();
        clear_ctrl();
        exp("wrap_sp", S_SP, 32'h000); exp("wrap_err", S_ERR, 1);
        step();
        pushPc_mem = 1; pc_in = 32'hAAAA_BBBB;
        exp("err_sticky", S_ERR, 1); exp("rstpc_addr", S_ADDR, 32'h000);
        step();
        rst = 1;
        exp("rsthi_we", S_WE, 0); exp("rsthi_stall", S_STALL, 0);
        step();
        rst = 0; clear_ctrl(); push_mem = 1; Rd_data_mem = 16'h2222;
        exp("rsthi_nowrite", S_MEM, 32'h1111, 12'hFFF);
        exp("rsthi_lo", S_MEM, 32'hBBBB, 12'h000);
        exp("rsthi_sp", S_SP, 32'hFFF); exp("rsthi_err", S_ERR, 0);
        exp("rsthi_idle", S_WDATA, 32'h2222); exp("rsthi_idle_stall", S_STALL, 0);
        step();
        clear_ctrl();
        step(); step();

        if (sb.size() != 0 || pc_q.size() != 0 || ccr_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expectations: got %0d pending, want 0",
                     sb.size() + pc_q.size() + ccr_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
